timeout_led_ctrl: RTL and testbench

- Downstream consumer of the timer's `timeout` pulse on the FPGA top level.
- Converts single-cycle timeout events into a human-visible LED pattern (stretched pulse or toggle) and counts events.
- Configured over the same sel/we/addr/wdata/rdata register bus the top-level init FSM uses for the timer.

---
 rtl/timeout_led_ctrl.sv | 174 +++++++++++++++++
 tb/tb_timeout_led_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timeout_led_ctrl.sv
// Timer timeout consumer: turns timeout pulses into a visible LED
// pattern (stretched pulse or toggle) and counts events.
module timeout_led_ctrl #(
  parameter int STRETCH_W       = 26,
  parameter int DEFAULT_STRETCH = 12_500_000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        timeout,
  output logic        led
);

  localparam logic [STRETCH_W-1:0] LP_DEF =
    STRETCH_W'(DEFAULT_STRETCH);

  typedef enum logic {IDLE, ON} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_ctrl;
  logic [STRETCH_W-1:0] r_stretch;
  logic [STRETCH_W-1:0] r_cnt;
  logic [STRETCH_W-1:0] w_cnt_nxt;
  logic [STRETCH_W-1:0] w_load;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ovf;
  logic                 r_led_raw;
  logic                 w_led_nxt;
  logic                 r_timeout_q;

  logic w_wr;
  logic w_rd;
  logic w_wr_ctrl;
  logic w_wr_str;
  logic w_wr_cnt;
  logic w_wr_stat;
  logic w_en;
  logic w_mode;
  logic w_retrig;
  logic w_event;
  logic w_force;
  logic w_cnt_sat;
  logic w_ovf_set;
  logic w_unused;

  assign w_wr      = sel & we;
  assign w_rd      = sel & ~we;
  assign w_wr_ctrl = w_wr && (addr[3:2] == 2'd0);
  assign w_wr_str  = w_wr && (addr[3:2] == 2'd1);
  assign w_wr_cnt  = w_wr && (addr[3:2] == 2'd2);
  assign w_wr_stat = w_wr && (addr[3:2] == 2'd3);

  assign w_en     = r_ctrl[0];
  assign w_mode   = r_ctrl[1];
  assign w_retrig = r_ctrl[2];
  assign w_event  = timeout & ~r_timeout_q & w_en;

  // Changing EN or MODE abandons whatever pattern is in flight
  assign w_force = w_wr_ctrl && (wdata[1:0] != r_ctrl[1:0]);

  assign w_load = (r_stretch == '0) ? '0
                : r_stretch - STRETCH_W'(1);

  assign w_cnt_sat = &r_count;
  assign w_ovf_set = w_event & w_cnt_sat & ~w_wr_cnt;

  assign led = r_led_raw ^ r_ctrl[3];

  assign w_unused = ^{addr, wdata};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_led_nxt   = r_led_raw;
    if (w_force || !w_en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_led_nxt   = 1'b0;
    end else if (w_mode) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      if (w_event) w_led_nxt = ~r_led_raw;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_event) begin
            w_state_nxt = ON;
            w_cnt_nxt   = w_load;
            w_led_nxt   = 1'b1;
          end
        end
        ON: begin
          if (w_event && w_retrig) begin
            w_cnt_nxt = w_load;
          end else if (r_cnt == '0) begin
            w_state_nxt = IDLE;
            w_led_nxt   = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - STRETCH_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_led_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_led_raw   <= 1'b0;
      r_timeout_q <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_led_raw   <= w_led_nxt;
      r_timeout_q <= timeout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_stretch <= LP_DEF;
    end else begin
      if (w_wr_ctrl) r_ctrl <= wdata[3:0];
      if (w_wr_str)  r_stretch <= wdata[STRETCH_W-1:0];
    end
  end

  // A clear racing an event leaves that event counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_wr_cnt) begin
      r_count <= CNT_W'(w_event);
    end else if (w_event && !w_cnt_sat) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_wr_stat && wdata[1]) begin
      r_ovf <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (w_rd) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, r_ctrl};
        2'd1:    rdata = 32'(r_stretch);
        2'd2:    rdata = 32'(r_count);
        default: rdata = {30'd0, r_ovf, r_led_raw};
      endcase
    end
  end

endmodule

// File: tb/tb_timeout_led_ctrl.sv
// Scoreboard bench for timeout_led_ctrl: stimulus queues expected
// values, a negedge monitor pops and compares them.
module tb_timeout_led_ctrl;

  localparam int DEF = 12_500_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        timeout = 1'b0;
  logic        led;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   kind = 0;
  int   led_hi = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  timeout_led_ctrl #(
    .STRETCH_W(26),
    .DEFAULT_STRETCH(DEF),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sel(sel),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .timeout(timeout),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic compare(input logic [31:0] act);
    exp_t e;
    n_chk++;
    if (q.size() == 0) begin
      $display("FAIL scoreboard_empty: actual %0d, no expectation",
               act);
    end else begin
      e = q.pop_front();
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d",
                    e.nm, act, e.exp);
    end
  endtask

  always @(negedge clk) begin
    if (kind == 3) begin
      compare(32'(led_hi));
      led_hi = 0;
    end else if (kind == 4) begin
      led_hi = 0;
    end else begin
      if (led === 1'b1) led_hi++;
      if (kind == 1) compare(rdata);
      if (kind == 2) compare({31'd0, led});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm  = nm;
    e.exp = v;
    q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v,
                    input string nm);
    expect_v(nm, v);
    sel = 1'b1; we = 1'b0; addr = a; kind = 1;
    tick();
    sel = 1'b0; kind = 0;
  endtask

  task automatic chk_led(input logic v, input string nm);
    expect_v(nm, {31'd0, v});
    kind = 2;
    tick();
    kind = 0;
  endtask

  task automatic chk_hi(input int v, input string nm);
    expect_v(nm, 32'(v));
    kind = 3;
    tick();
    kind = 0;
  endtask

  task automatic clr_hi();
    kind = 4;
    tick();
    kind = 0;
  endtask

  task automatic pulse();
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    rd(32'h4, DEF, "rst_stretch");
    rd(32'h0, 0, "rst_ctrl");
    rd(32'h8, 0, "rst_count");
    rd(32'hC, 0, "rst_status");
    chk_led(1'b0, "rst_led");

    wr(32'h4, 5);
    wr(32'h0, 1);
    clr_hi();
    pulse();
    repeat (10) tick();
    chk_hi(5, "stretch5_len");
    rd(32'h8, 1, "stretch5_count");

    wr(32'h4, 10);
    wr(32'h0, 5);
    wr(32'h8, 0);
    clr_hi();
    pulse();
    repeat (2) tick();
    pulse();
    repeat (20) tick();
    chk_hi(14, "retrig_len");
    rd(32'h8, 2, "retrig_count");

    wr(32'h0, 1);
    wr(32'h8, 0);
    clr_hi();
    pulse();
    repeat (2) tick();
    pulse();
    repeat (20) tick();
    chk_hi(10, "noretrig_len");
    rd(32'h8, 2, "noretrig_count");

    wr(32'h0, 3);
    wr(32'h8, 0);
    pulse();
    chk_led(1'b1, "toggle1");
    pulse();
    chk_led(1'b0, "toggle2");
    pulse();
    chk_led(1'b1, "toggle3");
    timeout = 1'b1;
    repeat (20) tick();
    timeout = 1'b0;
    tick();
    chk_led(1'b0, "toggle_level");
    rd(32'h8, 4, "toggle_count");

    wr(32'h8, 0);
    for (int i = 0; i < 17; i++) pulse();
    rd(32'h8, 15, "sat_count");
    rd(32'hC, 3, "sat_status");
    wr(32'hC, 2);
    rd(32'hC, 1, "ovf_w1c");
    timeout = 1'b1;
    wr(32'h8, 0);
    timeout = 1'b0;
    tick();
    rd(32'h8, 1, "clr_vs_event");
    for (int i = 0; i < 14; i++) pulse();
    rd(32'h8, 15, "resat_count");
    timeout = 1'b1;
    wr(32'hC, 2);
    timeout = 1'b0;
    tick();
    rd(32'hC, 3, "w1c_vs_ovf");

    wr(32'h0, 1);
    wr(32'h4, 0);
    clr_hi();
    pulse();
    repeat (4) tick();
    chk_hi(1, "stretch0_len");

    wr(32'h0, 8);
    wr(32'h8, 0);
    chk_led(1'b1, "pol_idle");
    pulse();
    pulse();
    chk_led(1'b1, "pol_events");
    rd(32'h8, 0, "dis_count");

    wr(32'h0, 1);
    wr(32'h4, 10);
    pulse();
    chk_led(1'b1, "pre_mode");
    wr(32'h0, 3);
    chk_led(1'b0, "mode_drop");
    rd(32'hC, 2, "mode_status");

    wr(32'h0, 1);
    pulse();
    chk_led(1'b1, "pre_reset");
    rst_n = 1'b0;
    chk_led(1'b0, "async_led");
    rd(32'h0, 0, "arst_ctrl");
    rd(32'h4, DEF, "arst_stretch");
    rd(32'h8, 0, "arst_count");
    rd(32'hC, 0, "arst_status");
    rst_n = 1'b1;
    repeat (2) tick();

    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL leftover: %0d expectations never checked, need 0",
               q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
